// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer for the 5-stage core: load-use stalls, taken-branch flushes,
// whole-pipe freeze on outstanding data-memory accesses, memory watchdog and stall counter.
module hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MemReadEX,
    input  logic [4:0]    RtEX,
    input  logic [4:0]    RsID,
    input  logic [4:0]    RtID,
    input  logic          UsesRtID,
    input  logic          BranchTakenID,
    input  logic          MemReqM,
    input  logic          MemReadyM,
    output logic          PCWrite,
    output logic          IFIDWrite,
    output logic          IFIDFlush,
    output logic          IDEXFlush,
    output logic          BackWrite,
    output logic          Halted,
    output logic [CW-1:0] StallCount
);

    localparam int WW = $clog2(MEM_TIMEOUT);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] MEMWAIT = 2'd1;
    localparam logic [1:0] HALT    = 2'd2;

    localparam logic [WW-1:0] WMAX = WW'(MEM_TIMEOUT - 1);
    localparam logic [WW-1:0] WONE = WW'(1);
    localparam logic [CW-1:0] SMAX = '1;
    localparam logic [CW-1:0] SONE = CW'(1);

    logic [1:0]    state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    logic halt_st, memfreeze, loaduse;

    assign halt_st   = (state_q == HALT);
    assign memfreeze = MemReqM & ~MemReadyM & ~halt_st;
    assign loaduse   = MemReadEX & (RtEX != 5'd0) &
                       ((RtEX == RsID) | (UsesRtID & (RtEX == RtID)));

    // Priority: halt > memory freeze > load-use bubble > branch flush > normal flow.
    always_comb begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        BackWrite = 1'b1;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        if (halt_st || memfreeze) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            BackWrite = 1'b0;
        end else if (loaduse) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end else if (BranchTakenID) begin
            IFIDFlush = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = '0;
        if (!halt_st) begin
            if (memfreeze) begin
                if (wcnt_q == WMAX) begin
                    state_d = HALT;
                end else begin
                    state_d = MEMWAIT;
                    wcnt_d  = wcnt_q + WONE;
                end
            end else begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PCWrite && !halt_st && (stall_cnt_q != SMAX))
            stall_cnt_d = stall_cnt_q + SONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Halted     = halt_st;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a default-sized instance plus a small one
// (MEM_TIMEOUT=4, CW=3) for the watchdog and counter saturation.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       MemReadEX, UsesRtID, BranchTakenID, MemReqM, MemReadyM;
    logic [4:0] RtEX, RsID, RtID;

    logic        pcw_m, ifidw_m, ifidf_m, idexf_m, backw_m, halt_m;
    logic [15:0] cnt_m;
    logic        pcw_s, ifidw_s, ifidf_s, idexf_s, backw_s, halt_s;
    logic [2:0]  cnt_s;
    logic [4:0]  outs_m, outs_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_controller u_dut (
        .clk(clk), .rst(rst), .MemReadEX(MemReadEX), .RtEX(RtEX), .RsID(RsID), .RtID(RtID),
        .UsesRtID(UsesRtID), .BranchTakenID(BranchTakenID), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .PCWrite(pcw_m), .IFIDWrite(ifidw_m), .IFIDFlush(ifidf_m), .IDEXFlush(idexf_m),
        .BackWrite(backw_m), .Halted(halt_m), .StallCount(cnt_m)
    );

    hazard_controller #(.MEM_TIMEOUT(4), .CW(3)) u_small (
        .clk(clk), .rst(rst), .MemReadEX(MemReadEX), .RtEX(RtEX), .RsID(RsID), .RtID(RtID),
        .UsesRtID(UsesRtID), .BranchTakenID(BranchTakenID), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .PCWrite(pcw_s), .IFIDWrite(ifidw_s), .IFIDFlush(ifidf_s), .IDEXFlush(idexf_s),
        .BackWrite(backw_s), .Halted(halt_s), .StallCount(cnt_s)
    );

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, BackWrite}
    assign outs_m = {pcw_m, ifidw_m, ifidf_m, idexf_m, backw_m};
    assign outs_s = {pcw_s, ifidw_s, ifidf_s, idexf_s, backw_s};

    localparam logic [4:0] O_IDLE = 5'b11001;
    localparam logic [4:0] O_LU   = 5'b00011;
    localparam logic [4:0] O_BR   = 5'b11101;
    localparam logic [4:0] O_HOLD = 5'b00000;

    typedef struct {
        logic       mrex;
        logic [4:0] rtex, rsid, rtid;
        logic       uses, br, req, rdy;
        logic [4:0] exp;
        int         inc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic mrex, input logic [4:0] rtex, input logic [4:0] rsid,
                       input logic [4:0] rtid, input logic uses, input logic br,
                       input logic req, input logic rdy);
        MemReadEX = mrex; RtEX = rtex; RsID = rsid; RtID = rtid;
        UsesRtID = uses; BranchTakenID = br; MemReqM = req; MemReadyM = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int exp_cnt;
        //            mrex rtex  rsid  rtid  uses br req rdy exp     inc
        vecs[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 0};
        vecs[1]  = '{1'b1, 5'd2, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,   1};
        vecs[2]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_IDLE, 0};
        vecs[3]  = '{1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 0};
        vecs[4]  = '{1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,   1};
        vecs[5]  = '{1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_IDLE, 0};
        vecs[6]  = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, O_BR,   0};
        vecs[7]  = '{1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_LU,   1};
        vecs[8]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_HOLD, 1};
        vecs[9]  = '{1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_HOLD, 1};
        vecs[10] = '{1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_LU,   1};
        vecs[11] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_IDLE, 0};
        vecs[12] = '{1'b0, 5'd6, 5'd6, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, O_BR,   0};

        drv(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset_outs", {27'd0, outs_m}, {27'd0, O_IDLE});
        chk("reset_halted", {31'd0, halt_m}, 32'd0);
        chk("reset_cnt", {16'd0, cnt_m}, 32'd0);
        chk("reset_cnt_small", {29'd0, cnt_s}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table of single-cycle vectors; StallCount tracked across edges
        exp_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk($sformatf("tbl_cnt_%0d", i), {16'd0, cnt_m}, exp_cnt);
            drv(vecs[i].mrex, vecs[i].rtex, vecs[i].rsid, vecs[i].rtid,
                vecs[i].uses, vecs[i].br, vecs[i].req, vecs[i].rdy);
            #1;
            chk($sformatf("tbl_outs_%0d", i), {27'd0, outs_m}, {27'd0, vecs[i].exp});
            exp_cnt += vecs[i].inc;
        end
        @(negedge clk);
        chk("tbl_cnt_end", {16'd0, cnt_m}, exp_cnt);

        // Load-use with a taken branch: stall first, flush the following cycle
        do_reset();
        drv(1, 2, 2, 0, 0, 1, 0, 0);
        #1;
        chk("lu_br_stall", {27'd0, outs_m}, {27'd0, O_LU});
        @(negedge clk);
        chk("lu_br_cnt", {16'd0, cnt_m}, 32'd1);
        drv(0, 2, 2, 0, 0, 1, 0, 0);
        #1;
        chk("lu_br_flush", {27'd0, outs_m}, {27'd0, O_BR});
        @(negedge clk);
        chk("lu_br_cnt2", {16'd0, cnt_m}, 32'd1);

        // Three-cycle memory wait, advance in the ready cycle
        do_reset();
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("mw_hold_%0d", c), {27'd0, outs_m}, {27'd0, O_HOLD});
            @(negedge clk);
        end
        MemReadyM = 1'b1;
        #1;
        chk("mw_ready", {27'd0, outs_m}, {27'd0, O_IDLE});
        @(negedge clk);
        chk("mw_cnt", {16'd0, cnt_m}, 32'd3);

        // Load-use hidden behind a freeze takes effect right after release
        drv(1, 3, 3, 0, 0, 0, 1, 0);
        #1;
        chk("mw_lu_hold", {27'd0, outs_m}, {27'd0, O_HOLD});
        @(negedge clk);
        MemReadyM = 1'b1;
        #1;
        chk("mw_lu_release", {27'd0, outs_m}, {27'd0, O_LU});
        @(negedge clk);
        chk("mw_lu_cnt", {16'd0, cnt_m}, 32'd5);

        // Watchdog on the small instance: halt after the 4th freeze cycle
        do_reset();
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) @(negedge clk);
        chk("wd_not_yet", {31'd0, halt_s}, 32'd0);
        chk("wd_cnt3", {29'd0, cnt_s}, 32'd3);
        @(negedge clk);
        chk("wd_halted", {31'd0, halt_s}, 32'd1);
        chk("wd_cnt4", {29'd0, cnt_s}, 32'd4);
        chk("wd_main_run", {31'd0, halt_m}, 32'd0);
        drv(0, 0, 0, 0, 0, 1, 0, 1);
        #1;
        chk("wd_outs_held", {27'd0, outs_s}, {27'd0, O_HOLD});
        chk("wd_main_branch", {27'd0, outs_m}, {27'd0, O_BR});
        repeat (2) @(negedge clk);
        chk("wd_sticky", {31'd0, halt_s}, 32'd1);
        chk("wd_cnt_frozen", {29'd0, cnt_s}, 32'd4);
        rst = 1'b0;
        #1;
        chk("wd_rst_halted", {31'd0, halt_s}, 32'd0);
        chk("wd_rst_cnt", {29'd0, cnt_s}, 32'd0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("wd_rst_outs", {27'd0, outs_s}, {27'd0, O_IDLE});
        rst = 1'b1;

        // Saturation: 10 stall cycles, small counter stops at 7
        do_reset();
        drv(1, 6, 6, 0, 0, 0, 0, 0);
        repeat (10) @(negedge clk);
        chk("sat_small", {29'd0, cnt_s}, 32'd7);
        chk("sat_main", {16'd0, cnt_m}, 32'd10);

        // Asynchronous reset in the middle of a freeze
        do_reset();
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) @(negedge clk);
        chk("midrst_pre", {16'd0, cnt_m}, 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_cnt", {16'd0, cnt_m}, 32'd0);
        chk("midrst_halted", {31'd0, halt_m}, 32'd0);
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline stall/flush sequencer for the 5-stage MIPS core. Detects load-use hazards and taken branches in ID and freezes the whole pipeline while a multi-cycle data-memory access in MEM is outstanding. Drives the write-enables and flush controls of PC, IF/ID, ID/EX and the back-end pipeline registers. A memory-wait watchdog halts the core, and a saturating stall counter records stalled cycles. Sits beside the forwarding unit; forwarding covers EX-stage RAW hazards that this block does not stall for.

## Interface
- MEM_TIMEOUT, 16: consecutive memory-freeze cycles tolerated before halting (≥2)
- CW, 16: width of StallCount

- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- MemReadEX  in  1  instruction in EX is a load
- RtEX  in  5  load destination register in EX
- RsID, RtID  in  5  source registers of instruction in ID
- UsesRtID  in  1  ID instruction reads Rt (R-type, store, beq)
- BranchTakenID  in  1  branch/jump resolved taken in ID
- MemReqM  in  1  MEM-stage access in progress
- MemReadyM  in  1  data memory completes access this cycle
- PCWrite  out  1  PC load enable
- IFIDWrite  out  1  IF/ID load enable
- IFIDFlush  out  1  clear IF/ID to NOP
- IDEXFlush  out  1  load bubble (all controls 0) into ID/EX
- BackWrite  out  1  load enable for ID/EX, EX/M and M/WB
- Halted  out  1  sticky watchdog halt
- StallCount  out  CW  saturating count of stalled cycles

## Operation
- States: RUN, MEMWAIT, HALT. A wait counter `wcnt` tracks memory-freeze cycles. Its range is 0..MEM_TIMEOUT-1.
- memfreeze = MemReqM & ~MemReadyM & (state≠HALT).
- loaduse = MemReadEX & (RtEX≠0) & ((RtEX==RsID) | (UsesRtID & RtEX==RtID)).
- Outputs are combinational from the current state and inputs. They are evaluated in priority order, highest first:
  1. HALT: PCWrite=IFIDWrite=BackWrite=0, and both flushes are 0.
  2. memfreeze: PCWrite=IFIDWrite=BackWrite=0, and both flushes are 0. The entire pipeline holds, with no bubble.
  3. loaduse: PCWrite=IFIDWrite=0, IDEXFlush=1, BackWrite=1, IFIDFlush=0. BranchTakenID is ignored this cycle and is re-evaluated after the stall.
  4. BranchTakenID: IFIDFlush=1. All write-enables are 1 and IDEXFlush=0.
  5. Otherwise: all write-enables are 1 and both flushes are 0.
- State transitions:
  - RUN→MEMWAIT on memfreeze.
  - MEMWAIT→RUN when MemReadyM=1 or MemReqM=0.
  - RUN/MEMWAIT→HALT when memfreeze holds and wcnt==MEM_TIMEOUT-1.
  - HALT exits only by reset.
- wcnt update: wcnt←wcnt+1 on each memfreeze cycle. It returns to 0 on any cycle without memfreeze.
- Halted=1 exactly when state==HALT.
- StallCount←StallCount+1 on each clock edge where PCWrite==0 and state≠HALT. It saturates at 2^CW−1 and never wraps.

## Timing
- Reset (rst=0, async): state=RUN, wcnt=0, StallCount=0, Halted=0. With idle inputs, outputs are PCWrite=IFIDWrite=BackWrite=1 and IFIDFlush=IDEXFlush=0.
- Control latency is zero. Outputs respond in the same cycle as the inputs and are sampled by the pipeline registers at the next posedge.
- Load-use stall is exactly 1 cycle. After the bubble, MemReadEX=0, so loaduse deasserts unless a new load is in EX.
- Memory freeze lasts as long as MemReqM&~MemReadyM. The pipeline advances in the MemReadyM cycle.
- Timeout: the MEM_TIMEOUT-th consecutive freeze cycle moves the state to HALT at its closing edge. Halted rises on the following cycle.
- Load-use coinciding with memfreeze: memfreeze wins. The load-use stall takes effect in the first cycle after release.
- Reset asserted mid-freeze or in HALT: immediate return to reset values, including clearing StallCount.

## Test plan
- Load-use: lw $2 in EX (MemReadEX=1, RtEX=2), RsID=2 → one cycle of PCWrite=0, IFIDWrite=0, IDEXFlush=1. Next cycle all enables are 1. StallCount 0→1.
- False hazard: RtEX=0, or RtEX=RtID=5 with UsesRtID=0 → no stall, StallCount unchanged.
- Branch: BranchTakenID=1 with no hazard → IFIDFlush=1 for 1 cycle. When combined with load-use → stall first, then flush in the next cycle.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then MemReadyM=1 → 3 cycles with all enables 0 and no flushes. Enables are 1 in the ready cycle. StallCount=3.
- Watchdog: MEM_TIMEOUT=4, MemReadyM held 0 → Halted=1 after 4 freeze cycles and stays high regardless of inputs. StallCount=4. Driving rst=0 clears everything.
- Saturation: CW=3, force 10 stall cycles → StallCount stops at 7.
